// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if
// Handshake and data bundle between the EX stage and the multiply/divide unit.
//   start, op, a, b  : operation request; op and operands are sampled on accept
//   flush            : cancel the in-flight operation
//   hi_we, lo_we,
//   wdata            : MTHI/MTLO writes
//   busy             : operation in flight, EX stage must stall
//   done             : one-cycle pulse, hi/lo already hold the result
//   div_by_zero      : qualifies done for a divide with a zero divisor
//   hi, lo           : architectural HI/LO registers
// The master modport belongs to the EX stage, the slave modport to the unit.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit
// Multi-cycle multiply/divide unit owning the MIPS HI/LO registers.
// Runs MULT/MULTU/DIV/DIVU (op 00/01/10/11) on operand magnitudes and fixes
// the signs when the result is committed; also services MTHI/MTLO writes.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mul_div_unit_if.slave (request, flush, MTHI/MTLO, status, HI/LO)
// Build option:
//   MDU_FAST_MUL_EN defined   : multiplies use a single-cycle WIDTH x WIDTH
//                               multiplier and commit one edge after accept
//   MDU_FAST_MUL_EN undefined : shift-add multiplier, one bit per cycle
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state;
  state_t             next_state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   opb;
  logic               neg_res;
  logic               neg_rem;
  logic               busy_r;
  logic               done_r;
  logic               dbz_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               accept;
  logic               commit;
  logic               iterate;
  logic               busy_next;
  logic               long_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   dvd_fix;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
`ifdef MDU_FAST_MUL_EN
`else
  logic [WIDTH:0]     mul_sum;
`endif

  // Signed ops work on magnitudes; the most negative value maps to 2^(WIDTH-1),
  // which still fits in WIDTH unsigned bits.
  always_comb begin
    a_neg = ~bus.op[0] & bus.a[WIDTH-1];
    b_neg = ~bus.op[0] & bus.b[WIDTH-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
  end

  // One restoring-division step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits. When it fits, the true
  // difference is below the divisor, so the low WIDTH bits are exact.
  always_comb begin
    div_shift = {acc, mq[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opb};
    div_sub   = div_shift[WIDTH-1:0] - opb;
    div_rem   = div_ge ? div_sub : div_shift[WIDTH-1:0];
  end

`ifdef MDU_FAST_MUL_EN
`else
  // One shift-add step: {acc, mq} shifts right while the partial product
  // accumulates in acc; after WIDTH steps {acc, mq} is the full product.
  always_comb begin
    mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, opb} : '0);
  end
`endif

  // Sign fix-up applied at commit. dvd_fix rebuilds the original dividend,
  // which HI receives on a divide by zero.
  always_comb begin
`ifdef MDU_FAST_MUL_EN
    prod_mag = {{WIDTH{1'b0}}, opb} * {{WIDTH{1'b0}}, mq};
`else
    prod_mag = {acc, mq};
`endif
    prod_fix = neg_res ? -prod_mag : prod_mag;
    quo_fix  = neg_res ? -mq : mq;
    rem_fix  = neg_rem ? -acc : acc;
    dvd_fix  = neg_rem ? -mq : mq;
  end

  // Next-state and control. Accept is evaluated in every state so that a
  // single-cycle op can be followed by a new one at its own commit edge.
  // Flush beats both commit and a simultaneous start.
  always_comb begin
    next_state = state;
    busy_next  = busy_r;
    commit     = 1'b0;
    accept     = bus.start & ~busy_r & ~bus.flush;
`ifdef MDU_FAST_MUL_EN
    long_op    = bus.op[1] & (bus.b != '0);
`else
    long_op    = ~bus.op[1] | (bus.b != '0);
`endif
    case (state)
`ifdef MDU_FAST_MUL_EN
      MUL:     commit = 1'b1;
`else
      MUL:     commit = (cnt == LAST);
`endif
      DIV:     commit = (opb == '0) | (cnt == LAST);
      default: commit = 1'b0;
    endcase
    if (bus.flush) begin
      commit = 1'b0;
    end
    iterate = (state != IDLE) & ~commit;
    if (bus.flush) begin
      next_state = IDLE;
      busy_next  = 1'b0;
    end else if (accept) begin
      next_state = bus.op[1] ? DIV : MUL;
      busy_next  = long_op;
    end else if (commit) begin
      next_state = IDLE;
      busy_next  = 1'b0;
    end
  end

  // State register plus the registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      state  <= next_state;
      busy_r <= busy_next;
      done_r <= commit;
      dbz_r  <= commit & (state == DIV) & (opb == '0);
    end
  end

  // Operand capture on accept, then one multiply or divide step per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      mq      <= '0;
      opb     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      acc     <= '0;
      mq      <= a_mag;
      opb     <= b_mag;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
    end else if (iterate) begin
      cnt <= cnt + 1'b1;
`ifdef MDU_FAST_MUL_EN
      acc <= div_rem;
      mq  <= {mq[WIDTH-2:0], div_ge};
`else
      if (state == DIV) begin
        acc <= div_rem;
        mq  <= {mq[WIDTH-2:0], div_ge};
      end else begin
        {acc, mq} <= {mul_sum, mq[WIDTH-1:1]};
      end
`endif
    end
  end

  // HI/LO: a committing op overrides any MTHI/MTLO write on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (commit) begin
      if (state == MUL) begin
        {hi_r, lo_r} <= prod_fix;
      end else if (opb == '0) begin
        hi_r <= dvd_fix;
        lo_r <= '1;
      end else begin
        hi_r <= rem_fix;
        lo_r <= quo_fix;
      end
    end else begin
      if (bus.hi_we) begin
        hi_r <= bus.wdata;
      end
      if (bus.lo_we) begin
        lo_r <= bus.wdata;
      end
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
// Self-checking bench for mul_div_unit at WIDTH=32. Expected HI/LO, flag and
// latency come from a behavioural model using the simulator's own arithmetic
// and are queued when an op is issued, then popped when done is seen.
module tb_mul_div_unit;
  localparam int WIDTH = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = WIDTH + 1;
`endif
  localparam int DIV_LAT = WIDTH + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(WIDTH)) bus ();

  mul_div_unit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model built on native 64-bit arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa;
    longint      sb;
    logic [63:0] r;
    logic [63:0] q;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    e.dbz = 1'b0;
    e.lat = DIV_LAT;
    case (op)
      2'b00: begin
        r     = sa * sb;
        e.hi  = r[63:32];
        e.lo  = r[31:0];
        e.lat = MUL_LAT;
      end
      2'b01: begin
        r     = {32'b0, a} * {32'b0, b};
        e.hi  = r[63:32];
        e.lo  = r[31:0];
        e.lat = MUL_LAT;
      end
      default: begin
        if (b == 32'b0) begin
          e.hi  = a;
          e.lo  = 32'hFFFF_FFFF;
          e.dbz = 1'b1;
          e.lat = 1;
        end else if (op == 2'b10) begin
          q    = sa / sb;
          r    = sa % sb;
          e.hi = r[31:0];
          e.lo = q[31:0];
        end else begin
          q    = {32'b0, a} / {32'b0, b};
          r    = {32'b0, a} % {32'b0, b};
          e.hi = r[31:0];
          e.lo = q[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // Waits for done (bounded), checking busy and the div_by_zero qualifier on
  // the way, then compares the popped scoreboard entry against HI/LO.
  // firstCycle is the cycle number reached before the call (0 = accept edge).
  task automatic waitDone(input string tag, input int firstCycle);
    exp_t e;
    int   k;
    int   busyErr;
    int   dbzErr;
    bit   seen;
    int   lat;
    k       = firstCycle;
    busyErr = 0;
    dbzErr  = 0;
    seen    = 1'b0;
    lat     = (sbq.size() > 0) ? sbq[0].lat : 0;
    while (!seen && k < 100) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (k < lat && !bus.busy) busyErr++;
        if (bus.div_by_zero) dbzErr++;
      end
    end
    checkOutput({tag, "_latency"}, seen ? k : -1, lat);
    checkOutput({tag, "_busy_in_flight"}, busyErr, 0);
    checkOutput({tag, "_dbz_without_done"}, dbzErr, 0);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (seen) begin
        checkOutput({tag, "_busy_at_done"}, bus.busy, 0);
        checkOutput({tag, "_hi"}, bus.hi, e.hi);
        checkOutput({tag, "_lo"}, bus.lo, e.lo);
        checkOutput({tag, "_dbz"}, bus.div_by_zero, e.dbz);
      end
    end
  endtask

  // Issues one op (accepted at the next edge), scrambles the operand inputs
  // afterwards, and waits for its result.
  task automatic applyStimulus(input string tag, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(op, a, b);
    sbq.push_back(e);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    if (e.lat == 1) checkOutput({tag, "_busy_cycle0"}, bus.busy, 0);
    waitDone(tag, 0);
  endtask

  // Counts done pulses over a window; used after flush and reset.
  task automatic countDone(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) n++;
    end
  endtask

  initial begin
    int   n;
    int   early;
    exp_t e;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_dbz", bus.div_by_zero, 0);
    checkOutput("reset_hi", bus.hi, 0);
    checkOutput("reset_lo", bus.lo, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed operations");
    applyStimulus("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
    checkOutput("mult_neg3x5_const_hi", bus.hi, 32'hFFFF_FFFF);
    checkOutput("mult_neg3x5_const_lo", bus.lo, 32'hFFFF_FFF1);
    applyStimulus("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("multu_max_const_hi", bus.hi, 32'hFFFF_FFFE);
    applyStimulus("mult_minxmin", 2'b00, 32'h8000_0000, 32'h8000_0000);
    applyStimulus("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    checkOutput("div_neg7by2_const_lo", bus.lo, 32'hFFFF_FFFD);
    applyStimulus("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("div_overflow_const_lo", bus.lo, 32'h8000_0000);
    applyStimulus("div_7byneg2", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE);
    applyStimulus("divu_big", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
    applyStimulus("divu_by_zero", 2'b11, 32'h0000_0007, 32'h0000_0000);
    checkOutput("divu_by_zero_const_hi", bus.hi, 32'h0000_0007);
    @(posedge clk);
    #1;
    checkOutput("done_pulse_width", bus.done, 0);
    checkOutput("dbz_cleared", bus.div_by_zero, 0);
    applyStimulus("div_neg_by_zero", 2'b10, 32'hFFFF_FFFB, 32'h0000_0000);

    $display("[TB] random operations");
    for (int i = 0; i < 10; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 4 == 3) ? 32'h0 : ((i % 4 == 2) ? 32'($urandom_range(1, 20)) : $urandom);
      applyStimulus($sformatf("rand%0d", i), rop, ra, rb);
    end

    $display("[TB] flush");
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    checkOutput("mthi", bus.hi, 32'h1234_5678);
    checkOutput("mtlo", bus.lo, 32'h1234_5678);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'd1000;
    bus.b     = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    checkOutput("flush_busy", bus.busy, 0);
    countDone(40, n);
    checkOutput("flush_no_done", n, 0);
    checkOutput("flush_hi_kept", bus.hi, 32'h1234_5678);
    checkOutput("flush_lo_kept", bus.lo, 32'h1234_5678);
    applyStimulus("divu_after_flush", 2'b11, 32'd100, 32'd7);
    checkOutput("divu_after_flush_const_lo", bus.lo, 32'h0000_000E);

    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'd50;
    bus.b     = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    checkOutput("flush_start_busy", bus.busy, 0);
    countDone(40, n);
    checkOutput("flush_start_no_done", n, 0);
    checkOutput("flush_start_lo_kept", bus.lo, 32'h0000_000E);

    $display("[TB] reset mid-op");
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midreset_busy", bus.busy, 0);
    checkOutput("midreset_hi", bus.hi, 0);
    countDone(40, n);
    checkOutput("midreset_no_done", n, 0);
    checkOutput("midreset_lo", bus.lo, 0);

    $display("[TB] start held, back-to-back, MTHI at commit");
    sbq.push_back(model(2'b10, 32'hFFFF_FFF9, 32'h0000_0002));
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'hFFFF_FFF9;
    bus.b     = 32'h0000_0002;
    @(posedge clk);
    #1;
    sbq.push_back(model(2'b11, 32'd100, 32'd7));
    bus.op    = 2'b11;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    early     = 0;
    for (int c = 1; c < DIV_LAT; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) early++;
      if (c == DIV_LAT - 1) begin
        bus.hi_we = 1'b1;
        bus.wdata = 32'hAAAA_5555;
      end
    end
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    checkOutput("held_no_early_done", early, 0);
    checkOutput("held_done", bus.done, 1);
    e = sbq.pop_front();
    checkOutput("held_commit_beats_mthi", bus.hi, e.hi);
    checkOutput("held_lo", bus.lo, e.lo);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b1;
    bus.wdata = 32'hAAAA_5555;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    checkOutput("mthi_in_flight", bus.hi, 32'hAAAA_5555);
    waitDone("b2b_second", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
